// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
//   mem_ctrl_e   : access size/sign encoding carried on req_ctrl
//   lsu_state_e  : load_store_unit FSM states
//   is_valid_ctrl: req_ctrl encodes a real access (000..100)
//   is_misaligned: access does not fit its natural alignment
package rv32i_lsu_pkg;

    typedef enum logic [2:0] {
        MC_B  = 3'b000,
        MC_H  = 3'b001,
        MC_W  = 3'b010,
        MC_HU = 3'b011,
        MC_BU = 3'b100
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_valid_ctrl(input logic [2:0] ctrl);
        return (ctrl <= MC_BU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (ctrl)
            MC_H, MC_HU: mis = off[0];
            MC_W:        mis = |off;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   ctrl_i   : access size/sign (mem_ctrl_e encoding)
//   offset_i : byte offset within the word (addr[1:0])
//   wdata_i  : right-justified store data
//   rdata_i  : raw memory read word
//   wstrb_o  : byte enables for a store of this size/offset
//   wdata_o  : store data replicated into every lane
//   rdata_o  : selected lane, sign- or zero-extended
// Misaligned halfwords use offset[1] only; words ignore the offset.
module lsu_align
    import rv32i_lsu_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (offset_i)
            2'd0:    rbyte = rdata_i[7:0];
            2'd1:    rbyte = rdata_i[15:8];
            2'd2:    rbyte = rdata_i[23:16];
            default: rbyte = rdata_i[31:24];
        endcase
        rhalf = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wstrb_o = '0;
        wdata_o = wdata_i;
        case (ctrl_i)
            MC_B, MC_BU: begin
                wstrb_o = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MC_H, MC_HU: begin
                wstrb_o = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            MC_W:    wstrb_o = 4'b1111;
            default: wstrb_o = '0;
        endcase
    end

    always_comb begin
        case (ctrl_i)
            MC_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
            MC_BU:   rdata_o = {24'h0, rbyte};
            MC_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
            MC_HU:   rdata_o = {16'h0, rhalf};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for an RV32I core driving a req/gnt/rvalid
// data-memory port. One access per instruction; the pipeline is stalled
// until the access completes (rsp_valid pulse).
//   Pipeline side : req_valid/req_we/req_ctrl/req_addr/req_wdata in,
//                   lsu_stall, rsp_valid, rsp_rdata, rsp_err out
//   Memory side   : mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata out,
//                   mem_gnt/mem_rvalid/mem_rdata in
// Parameter TIMEOUT_CYCLES: cycles spent in REQ or WAIT before aborting
// with rsp_err (min 2).
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned H/HU/W
// accesses complete immediately with rsp_err and never reach memory;
// otherwise the offset is truncated and the access proceeds.
module load_store_unit
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:2]      addr_q, addr_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [1:0]       off_q, off_d;
    logic [3:0]       strb_q, strb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [2:0]  al_ctrl;
    logic [1:0]  al_off;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        req_bad;
    logic        timeout;

    // The aligner is shared: in IDLE it shapes the incoming store, in WAIT
    // it extracts load data for the request already registered.
    assign al_ctrl = (state_q == IDLE) ? req_ctrl       : ctrl_q;
    assign al_off  = (state_q == IDLE) ? req_addr[1:0]  : off_q;

    lsu_align u_align (
        .ctrl_i   (al_ctrl),
        .offset_i (al_off),
        .wdata_i  (req_wdata),
        .rdata_i  (mem_rdata),
        .wstrb_o  (al_wstrb),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    always_comb begin
        req_bad = !is_valid_ctrl(req_ctrl);
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = req_bad | is_misaligned(req_ctrl, req_addr[1:0]);
`endif
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        ctrl_d  = ctrl_q;
        off_d   = off_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (req_bad) begin
                        state_d = DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        we_d    = req_we;
                        addr_d  = req_addr[31:2];
                        ctrl_d  = req_ctrl;
                        off_d   = req_addr[1:0];
                        strb_d  = req_we ? al_wstrb : 4'b0000;
                        wdata_d = al_wdata;
                    end
                end
            end
            REQ: begin
                // rvalid in the grant cycle is deliberately not looked at here.
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = DONE;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    rdata_d = al_rdata;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            off_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
            off_q   <= off_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wstrb = strb_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign lsu_stall = req_valid & (state_q != DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
// Honors LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;

    localparam int T     = 16;
    localparam int LIMIT = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr, req_wdata;
    logic        lsu_stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // observations from the last run_access
    int          obs_lat, obs_nreq;
    logic        obs_done, obs_we, obs_err, obs_unstable, obs_stall_busy, obs_stall_done, obs_memreq_done;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_strb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_stall(lsu_stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'd0, 3'd4: return 1;
            3'd1, 3'd3: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_bad(input logic [2:0] c, input logic [31:0] a);
        if (size_of(c) == 0) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % size_of(c)) != 0) return 1'b1;
`else
        if (a[31] === 1'bx) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // first byte of the access within the word after truncating to natural alignment
    function automatic int start_of(input logic [2:0] c, input logic [31:0] a);
        int sz;
        sz = size_of(c);
        return int'(a[1:0]) - (int'(a[1:0]) % sz);
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] c, input logic [31:0] a);
        logic [3:0] s;
        int st, sz;
        st = start_of(c, a);
        sz = size_of(c);
        for (int i = 0; i < 4; i++) s[i] = (i >= st) && (i < st + sz);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = size_of(c);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int st, sz;
        sz = size_of(c);
        st = start_of(c, a);
        v  = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = w[8*(st+k) +: 8];
        if ((c == 3'd0 || c == 3'd1) && v[8*sz-1])
            for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- driver (records observations, checks nothing) ----------------
    // gnt_wait: REQ cycles before grant; rv_wait: cycles from grant to rvalid;
    // dup_rv: also raise rvalid (with wrong data) in the grant cycle.
    task automatic run_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gnt_wait, input int rv_wait,
                              input logic [31:0] rword, input logic dup_rv);
        int gnt_cyc;
        obs_done = 0; obs_lat = 0; obs_nreq = 0; obs_unstable = 0; obs_stall_busy = 1;
        obs_stall_done = 1; obs_memreq_done = 1; obs_err = 1'bx; obs_rdata = 'x;
        obs_addr = 'x; obs_we = 1'bx; obs_strb = 'x; obs_wdata = 'x;
        gnt_cyc = -1;
        @(negedge clk);
        req_valid = 1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        mem_gnt = 0; mem_rvalid = 0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                obs_done = 1; obs_lat = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
                obs_stall_done = lsu_stall; obs_memreq_done = mem_req;
                break;
            end
            if (!lsu_stall) obs_stall_busy = 0;
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (mem_req) begin
                if (obs_nreq == 0) begin
                    obs_addr = mem_addr; obs_we = mem_we; obs_strb = mem_wstrb; obs_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {obs_addr, obs_we, obs_strb, obs_wdata}) begin
                    obs_unstable = 1;
                end
                if (obs_nreq == gnt_wait) begin
                    mem_gnt = 1; gnt_cyc = c;
                    if (dup_rv) begin mem_rvalid = 1; mem_rdata = ~rword; end
                end
                obs_nreq++;
            end else if (gnt_cyc >= 0 && c - gnt_cyc == rv_wait) begin
                mem_rvalid = 1; mem_rdata = rword;
            end
        end
        req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_we = 0; req_ctrl = 0; req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #12;
        n_checks++; if ({rsp_valid, rsp_err, mem_req, mem_we, lsu_stall, mem_wstrb} !== 9'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {rsp_valid, rsp_err, mem_req, mem_we, lsu_stall, mem_wstrb}); end
        n_checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'b0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected 0", mem_addr, mem_wdata, rsp_rdata); end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        n_checks++; if ({rsp_valid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b expected 00", {rsp_valid, mem_req}); end
    endtask

    task automatic test_store_word();
        run_access(1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 1, 0, 0);
        n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2 (0 = no response in bound)", obs_lat); end
        n_checks++; if (obs_addr !== 32'h104) begin n_fail++; $display("FAIL sw_addr: got %h expected 00000104", obs_addr); end
        n_checks++; if (obs_strb !== 4'b1111) begin n_fail++; $display("FAIL sw_strb: got %b expected 1111", obs_strb); end
        n_checks++; if ({obs_we, obs_wdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL sw_wdata: got %b/%h expected 1/deadbeef", obs_we, obs_wdata); end
        n_checks++; if ({obs_stall_busy, obs_stall_done} !== 2'b10) begin n_fail++; $display("FAIL sw_stall: got %b expected 10", {obs_stall_busy, obs_stall_done}); end
        n_checks++; if ({obs_err, obs_rdata} !== 33'b0) begin n_fail++; $display("FAIL sw_rsp: err %b rdata %h expected 0/0", obs_err, obs_rdata); end
    endtask

    task automatic test_byte();
        run_access(1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 0, 0);
        n_checks++; if (obs_strb !== 4'b1000) begin n_fail++; $display("FAIL sb_strb: got %b expected 1000", obs_strb); end
        n_checks++; if (obs_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", obs_wdata); end
        n_checks++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h expected 00000100", obs_addr); end
        run_access(0, 3'b000, 32'h103, 0, 0, 2, 32'hA5000000, 0);
        n_checks++; if (obs_rdata !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffffa5", obs_rdata); end
        n_checks++; if (obs_lat !== 4) begin n_fail++; $display("FAIL lb_latency: got %0d expected 4", obs_lat); end
        n_checks++; if ({obs_we, obs_strb} !== 5'b0) begin n_fail++; $display("FAIL lb_strb: got %b expected 00000", {obs_we, obs_strb}); end
    endtask

    task automatic test_half();
        run_access(0, 3'b011, 32'h102, 0, 1, 1, 32'h80011234, 0);
        n_checks++; if (obs_rdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 00008001", obs_rdata); end
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h00008001}) begin n_fail++; $display("FAIL lhu_hold: valid %b rdata %h expected 0/00008001", rsp_valid, rsp_rdata); end
        run_access(0, 3'b001, 32'h100, 0, 0, 1, 32'h80011234, 0);
        n_checks++; if (obs_rdata !== 32'h00001234) begin n_fail++; $display("FAIL lh_rdata: got %h expected 00001234", obs_rdata); end
        n_checks++; if (obs_lat !== 3) begin n_fail++; $display("FAIL lh_latency: got %0d expected 3", obs_lat); end
    endtask

    task automatic test_misalign();
        run_access(0, 3'b010, 32'h106, 0, 0, 1, 32'h13579BDF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if ({obs_nreq, obs_lat} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL lw_mis_trap: nreq %0d lat %0d expected 0/1", obs_nreq, obs_lat); end
        n_checks++; if ({obs_err, obs_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL lw_mis_err: err %b rdata %h expected 1/0", obs_err, obs_rdata); end
`else
        n_checks++; if (obs_addr !== 32'h104) begin n_fail++; $display("FAIL lw_mis_addr: got %h expected 00000104", obs_addr); end
        n_checks++; if ({obs_err, obs_rdata} !== {1'b0, 32'h13579BDF}) begin n_fail++; $display("FAIL lw_mis_rsp: err %b rdata %h expected 0/13579bdf", obs_err, obs_rdata); end
`endif
    endtask

    task automatic test_invalid();
        for (int c = 5; c <= 7; c++) begin
            run_access(c[0], 3'(c), 32'h200, 32'h11, 0, 1, 0, 0);
            n_checks++; if ({obs_nreq, obs_lat, obs_err, obs_rdata} !== {32'd0, 32'd1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL invalid_ctrl%0d: nreq %0d lat %0d err %b rdata %h expected 0/1/1/0", c, obs_nreq, obs_lat, obs_err, obs_rdata); end
        end
    endtask

    task automatic test_timeout();
        run_access(1, 3'b010, 32'h300, 32'h55, 100, 1, 0, 0);
        n_checks++; if ({obs_lat, obs_nreq} !== {32'(T + 1), 32'(T)}) begin n_fail++; $display("FAIL tmo_req: lat %0d nreq %0d expected %0d/%0d", obs_lat, obs_nreq, T + 1, T); end
        n_checks++; if ({obs_err, obs_memreq_done} !== 2'b10) begin n_fail++; $display("FAIL tmo_req_err: err %b mem_req %b expected 1/0", obs_err, obs_memreq_done); end
        @(negedge clk);
        n_checks++; if ({rsp_valid, mem_req, rsp_err} !== 3'b001) begin n_fail++; $display("FAIL tmo_idle: got %b expected 001", {rsp_valid, mem_req, rsp_err}); end
        run_access(0, 3'b010, 32'h304, 0, 1, 100, 0, 0);
        n_checks++; if ({obs_lat, obs_err} !== {32'(T + 3), 1'b1}) begin n_fail++; $display("FAIL tmo_wait: lat %0d err %b expected %0d/1", obs_lat, obs_err, T + 3); end
        run_access(1, 3'b010, 32'h308, 32'h77, 0, 1, 0, 0);
        n_checks++; if ({obs_lat, obs_err, obs_strb} !== {32'd2, 1'b0, 4'b1111}) begin n_fail++; $display("FAIL tmo_recover: lat %0d err %b strb %b expected 2/0/1111", obs_lat, obs_err, obs_strb); end
    endtask

    task automatic test_gnt_rvalid_same();
        run_access(0, 3'b010, 32'h400, 0, 0, 2, 32'hCAFEF00D, 1);
        n_checks++; if ({obs_lat, obs_rdata} !== {32'd4, 32'hCAFEF00D}) begin n_fail++; $display("FAIL gnt_rv_same: lat %0d rdata %h expected 4/cafef00d", obs_lat, obs_rdata); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_ctrl = 3'b010; req_addr = 32'h500; mem_gnt = 0; mem_rvalid = 0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b expected 1", mem_req); end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        n_checks++; if ({mem_req, rsp_valid, lsu_stall} !== 3'b001) begin n_fail++; $display("FAIL rmid_wait: got %b expected 001", {mem_req, rsp_valid, lsu_stall}); end
        #2; rst_n = 0; req_valid = 0; #1;
        n_checks++; if ({rsp_valid, rsp_err, mem_req, mem_we, lsu_stall, mem_wstrb, mem_addr, mem_wdata, rsp_rdata} !== '0) begin n_fail++; $display("FAIL rmid_async: addr %h req %b valid %b expected all 0", mem_addr, mem_req, rsp_valid); end
        @(negedge clk); rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_req) seen = 1;
            if (i == 1) mem_rvalid = 0;
        end
        n_checks++; if ({seen, rsp_rdata} !== 33'b0) begin n_fail++; $display("FAIL rmid_late_rvalid: seen %b rdata %h expected 0/0", seen, rsp_rdata); end
        run_access(1, 3'b010, 32'h504, 32'h9, 0, 1, 0, 0);
        n_checks++; if ({obs_lat, obs_err} !== {32'd2, 1'b0}) begin n_fail++; $display("FAIL rmid_recover: lat %0d err %b expected 2/0", obs_lat, obs_err); end
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic        we, dup, bad;
        logic [31:0] a, d, w, e_rd;
        int          gw, rv, e_lat;
        for (int n = 0; n < 60; n++) begin
            c   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            we  = (c <= 3'd2 || c >= 3'd5) ? 1'($urandom) : 1'b0;
            a   = $urandom; d = $urandom; w = $urandom;
            gw  = $urandom_range(0, 3); rv = $urandom_range(1, 3); dup = 1'($urandom);
            bad = model_bad(c, a);
            run_access(we, c, a, d, gw, rv, w, dup);
            if (bad) begin
                e_lat = 1; e_rd = 0;
            end else if (we) begin
                e_lat = gw + 2; e_rd = 0;
            end else begin
                e_lat = gw + rv + 2; e_rd = model_load(c, a, w);
            end
            n_checks++; if ({obs_lat, obs_err, obs_rdata} !== {32'(e_lat), bad, e_rd}) begin n_fail++; $display("FAIL rnd%0d_rsp: ctrl %0d we %b addr %h lat %0d err %b rdata %h expected %0d/%b/%h", n, c, we, a, obs_lat, obs_err, obs_rdata, e_lat, bad, e_rd); end
            n_checks++; if ({obs_stall_busy, obs_stall_done, obs_unstable} !== 3'b100) begin n_fail++; $display("FAIL rnd%0d_stall: got %b expected 100", n, {obs_stall_busy, obs_stall_done, obs_unstable}); end
            if (bad) begin
                n_checks++; if (obs_nreq !== 0) begin n_fail++; $display("FAIL rnd%0d_noreq: nreq %0d expected 0", n, obs_nreq); end
            end else begin
                n_checks++; if ({obs_nreq, obs_addr, obs_we} !== {32'(gw + 1), a & 32'hFFFF_FFFC, we}) begin n_fail++; $display("FAIL rnd%0d_req: nreq %0d addr %h we %b expected %0d/%h/%b", n, obs_nreq, obs_addr, obs_we, gw + 1, a & 32'hFFFF_FFFC, we); end
                if (we) begin
                    n_checks++; if ({obs_strb, obs_wdata} !== {model_strb(c, a), model_wdata(c, d)}) begin n_fail++; $display("FAIL rnd%0d_store: strb %b wdata %h expected %b/%h", n, obs_strb, obs_wdata, model_strb(c, a), model_wdata(c, d)); end
                end else begin
                    n_checks++; if (obs_strb !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_load_strb: got %b expected 0000", n, obs_strb); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_misalign();
        test_invalid();
        test_timeout();
        test_gnt_rvalid_same();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

endmodule
